// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: per-register load/bubble controls, load-use and fetch-kill.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned MEM_STAGE  = 3,
    parameter int unsigned BR_STAGE   = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  imem_read,
    input  logic                  imem_resp,
    input  logic                  dmem_access,
    input  logic                  dmem_resp,
    input  logic                  redirect,
    input  logic                  ex_is_load,
    input  logic [4:0]            ex_rd,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    output logic                  load_pc,
    output logic [NUM_STAGES-2:0] stage_load,
    output logic [NUM_STAGES-2:0] stage_flush,
    output logic                  imem_discard,
    output logic [CNT_W-1:0]      perf_cycles,
    output logic [CNT_W-1:0]      perf_stalls,
    output logic [CNT_W-1:0]      perf_flushes
);

    localparam int unsigned NumRegs = NUM_STAGES - 1;

    typedef enum logic [0:0] {FRun, FKill} fetch_state_e;

    fetch_state_e state_q, state_d;
    logic         redir_pend_q, redir_pend_d;
    logic         dstall, lu, redir_eff, istall;
    logic         flush_evt;

    assign dstall    = dmem_access & ~dmem_resp;
    assign lu        = ex_is_load & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign redir_eff = redirect | redir_pend_q;

    // Outstanding wrong-path fetch: its response must not reach IF.
    assign imem_discard = rst & (state_q == FKill) & imem_resp;
    assign istall       = ~imem_resp | imem_discard;

    always_comb begin
        load_pc      = 1'b0;
        stage_load   = '1;
        stage_flush  = '0;
        state_d      = state_q;
        redir_pend_d = redir_pend_q;
        flush_evt    = 1'b0;

        if ((state_q == FKill) && imem_resp) begin
            state_d = FRun;
        end

        if (!rst) begin
            stage_flush = '1;
        end else if (dstall) begin
            // Hold everything up to MEM, bubble the register behind it.
            for (int unsigned i = 0; i < NumRegs; i++) begin
                if (i < MEM_STAGE) begin
                    stage_load[i] = 1'b0;
                end else if (i == MEM_STAGE) begin
                    stage_flush[i] = 1'b1;
                end
            end
            if (redirect) begin
                redir_pend_d = 1'b1;
            end
        end else if (redir_eff) begin
            load_pc = 1'b1;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                if (i < BR_STAGE) begin
                    stage_flush[i] = 1'b1;
                end
            end
            redir_pend_d = 1'b0;
            flush_evt    = 1'b1;
            if ((state_q == FRun) && imem_read && !imem_resp) begin
                state_d = FKill;
            end
        end else if (lu) begin
            stage_load[0]  = 1'b0;
            stage_flush[1] = 1'b1;
        end else if (istall) begin
            stage_flush[0] = 1'b1;
        end else begin
            load_pc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FRun;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cycles_q, stalls_q, flushes_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cycles_q  <= '0;
            stalls_q  <= '0;
            flushes_q <= '0;
        end else begin
            cycles_q <= cycles_q + CntOne;
            if (!load_pc) begin
                stalls_q <= stalls_q + CntOne;
            end
            if (flush_evt) begin
                flushes_q <= flushes_q + CntOne;
            end
        end
    end

    assign perf_cycles  = cycles_q;
    assign perf_stalls  = stalls_q;
    assign perf_flushes = flushes_q;
`else
    logic unused_flush_evt;
    assign unused_flush_evt = flush_evt;

    assign perf_cycles  = '0;
    assign perf_stalls  = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (NUM_STAGES=5, MEM_STAGE=3, BR_STAGE=3).
// Counter expectations follow PIPE_CTRL_PERF_EN; counters read 0 when it is undefined.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read, imem_resp, dmem_access, dmem_resp, redirect;
    logic        ex_is_load, id_use_rs1, id_use_rs2;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        load_pc, imem_discard;
    logic [3:0]  stage_load, stage_flush;
    logic [31:0] perf_cycles, perf_stalls, perf_flushes;
    logic [9:0]  ctl;

    int checks = 0;
    int errors = 0;

    // {load_pc, stage_load, stage_flush, imem_discard}
    localparam logic [9:0] CIdle    = 10'b1_1111_0000_0;
    localparam logic [9:0] CReset   = 10'b0_1111_1111_0;
    localparam logic [9:0] CDstall  = 10'b0_1000_1000_0;
    localparam logic [9:0] CLu      = 10'b0_1110_0010_0;
    localparam logic [9:0] CRedir   = 10'b1_1111_0111_0;
    localparam logic [9:0] CIstall  = 10'b0_1111_0001_0;
    localparam logic [9:0] CDiscard = 10'b0_1111_0001_1;

    assign ctl = {load_pc, stage_load, stage_flush, imem_discard};

    pipe_ctrl #(
        .NUM_STAGES(5),
        .MEM_STAGE (3),
        .BR_STAGE  (3),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_read   (imem_read),
        .imem_resp   (imem_resp),
        .dmem_access (dmem_access),
        .dmem_resp   (dmem_resp),
        .redirect    (redirect),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .load_pc     (load_pc),
        .stage_load  (stage_load),
        .stage_flush (stage_flush),
        .imem_discard(imem_discard),
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls),
        .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        imem_read   = 1'b1;
        imem_resp   = 1'b1;
        dmem_access = 1'b0;
        dmem_resp   = 1'b0;
        redirect    = 1'b0;
        ex_is_load  = 1'b0;
        ex_rd       = 5'd0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_idle();
        tick();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        tick();
        tick();
        checks++;
        if (ctl !== CReset) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", ctl, CReset);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_cycles got %0d exp 0", perf_cycles);
        end
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL idle_ctl got %b exp %b", ctl, CIdle);
        end
        for (int n = 1; n <= 3; n++) begin
            tick();
            checks++;
            if (perf_cycles !== (PerfEn ? 32'(n) : 32'd0)) begin
                errors++;
                $display("FAIL cycles_%0d got %0d exp %0d", n, perf_cycles, PerfEn ? n : 0);
            end
        end
        checks++;
        if (perf_stalls !== 32'd0) begin
            errors++;
            $display("FAIL idle_stalls got %0d exp 0", perf_stalls);
        end
    endtask

    task automatic test_dstall();
        do_reset();
        dmem_access = 1'b1;
        dmem_resp   = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (ctl !== CDstall) begin
                errors++;
                $display("FAIL dstall_c%0d got %b exp %b", n, ctl, CDstall);
            end
            tick();
        end
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL dstall_release got %b exp %b", ctl, CIdle);
        end
        checks++;
        if (perf_stalls !== (PerfEn ? 32'd3 : 32'd0)) begin
            errors++;
            $display("FAIL dstall_stalls got %0d exp %0d", perf_stalls, PerfEn ? 3 : 0);
        end
        tick();
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_is_load = 1'b1;
        ex_rd      = 5'd5;
        id_rs2     = 5'd5;
        id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (ctl !== CLu) begin
            errors++;
            $display("FAIL lu_rs2 got %b exp %b", ctl, CLu);
        end
        ex_rd  = 5'd0;
        id_rs2 = 5'd0;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL lu_x0 got %b exp %b", ctl, CIdle);
        end
        ex_rd      = 5'd7;
        id_rs1     = 5'd7;
        id_use_rs1 = 1'b1;
        id_use_rs2 = 1'b0;
        #1;
        checks++;
        if (ctl !== CLu) begin
            errors++;
            $display("FAIL lu_rs1 got %b exp %b", ctl, CLu);
        end
        id_use_rs1 = 1'b0;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL lu_unused got %b exp %b", ctl, CIdle);
        end
        ex_is_load = 1'b0;
        id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL lu_notload got %b exp %b", ctl, CIdle);
        end
        set_idle();
    endtask

    task automatic test_redirect_in_dstall();
        do_reset();
        dmem_access = 1'b1;
        dmem_resp   = 1'b0;
        redirect    = 1'b1;
        #1;
        checks++;
        if (ctl !== CDstall) begin
            errors++;
            $display("FAIL rds_c0 got %b exp %b", ctl, CDstall);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (ctl !== CDstall) begin
            errors++;
            $display("FAIL rds_c1 got %b exp %b", ctl, CDstall);
        end
        tick();
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (ctl !== CRedir) begin
            errors++;
            $display("FAIL rds_release got %b exp %b", ctl, CRedir);
        end
        tick();
        checks++;
        if (perf_flushes !== (PerfEn ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL rds_flushes got %0d exp %0d", perf_flushes, PerfEn ? 1 : 0);
        end
        dmem_access = 1'b0;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL rds_pend_clear got %b exp %b", ctl, CIdle);
        end
        set_idle();
    endtask

    task automatic test_fetch_kill();
        do_reset();
        imem_resp = 1'b0;
        redirect  = 1'b1;
        #1;
        checks++;
        if (ctl !== CRedir) begin
            errors++;
            $display("FAIL fk_redir got %b exp %b", ctl, CRedir);
        end
        tick();
        redirect = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (ctl !== CIstall) begin
                errors++;
                $display("FAIL fk_wait%0d got %b exp %b", n, ctl, CIstall);
            end
            tick();
        end
        imem_resp = 1'b1;
        #1;
        checks++;
        if (ctl !== CDiscard) begin
            errors++;
            $display("FAIL fk_discard got %b exp %b", ctl, CDiscard);
        end
        tick();
        checks++;
        if ({perf_cycles, perf_stalls, perf_flushes} !==
            (PerfEn ? {32'd4, 32'd3, 32'd1} : 96'd0)) begin
            errors++;
            $display("FAIL fk_counters got %0d/%0d/%0d", perf_cycles, perf_stalls, perf_flushes);
        end
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL fk_resume got %b exp %b", ctl, CIdle);
        end
        // Second redirect while killing keeps the kill pending.
        imem_resp = 1'b0;
        redirect  = 1'b1;
        tick();
        #1;
        checks++;
        if (ctl !== CRedir) begin
            errors++;
            $display("FAIL fk_redir2 got %b exp %b", ctl, CRedir);
        end
        tick();
        redirect  = 1'b0;
        imem_resp = 1'b1;
        #1;
        checks++;
        if (ctl !== CDiscard) begin
            errors++;
            $display("FAIL fk_discard2 got %b exp %b", ctl, CDiscard);
        end
        tick();
        // Redirect coinciding with a response does not arm the kill.
        redirect = 1'b1;
        #1;
        checks++;
        if (ctl !== CRedir) begin
            errors++;
            $display("FAIL fk_same_redir got %b exp %b", ctl, CRedir);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (ctl !== CIdle) begin
            errors++;
            $display("FAIL fk_same_next got %b exp %b", ctl, CIdle);
        end
        set_idle();
    endtask

    task automatic test_lu_vs_redirect();
        do_reset();
        ex_is_load = 1'b1;
        ex_rd      = 5'd9;
        id_rs1     = 5'd9;
        id_use_rs1 = 1'b1;
        redirect   = 1'b1;
        #1;
        checks++;
        if (ctl !== CRedir) begin
            errors++;
            $display("FAIL lu_redir got %b exp %b", ctl, CRedir);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (ctl !== CLu) begin
            errors++;
            $display("FAIL lu_after_redir got %b exp %b", ctl, CLu);
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        test_reset();
        test_dstall();
        test_load_use();
        test_redirect_in_dstall();
        test_fetch_kill();
        test_lu_vs_redirect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
